// File: rtl/puf_window_counter.sv
// Ring-oscillator PUF window counter: warms up both oscillators, counts their
// synchronized edge pulses over a fixed window, then publishes the two totals.
module puf_window_counter #(
  parameter int unsigned WINDOW_CYCLES = 65536,
  parameter int unsigned SETTLE_CYCLES = 16
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        start,
  input  logic        ro_pulse_a,
  input  logic        ro_pulse_b,
  output logic        ro_enable,
  output logic        busy,
  output logic [31:0] count1,
  output logic [31:0] count2,
  output logic        counts_valid
);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    SETTLE = 2'd1,
    COUNT  = 2'd2,
    DONE   = 2'd3
  } state_t;

  localparam logic [24:0] SETTLE_LAST = 25'(SETTLE_CYCLES - 1);
  localparam logic [24:0] WINDOW_LAST = 25'(WINDOW_CYCLES - 1);

  state_t      r_state;
  state_t      w_state_next;
  logic [24:0] r_phase;
  logic        w_phase_clear;
  logic [31:0] r_acc [2];
  logic [31:0] w_acc_next [2];
  logic [1:0]  w_pulse;

  assign w_pulse = {ro_pulse_b, ro_pulse_a};

  // Saturating increment per channel; index 0 is RO A, index 1 is RO B.
  generate
    for (genvar gi = 0; gi < 2; gi++) begin : g_acc
      always_comb begin
        w_acc_next[gi] = r_acc[gi];
        if (w_pulse[gi] && (r_acc[gi] != 32'hFFFF_FFFF)) begin
          w_acc_next[gi] = r_acc[gi] + 32'd1;
        end
      end
    end
  endgenerate

  always_comb begin
    w_state_next  = r_state;
    w_phase_clear = 1'b0;
    case (r_state)
      IDLE: begin
        if (start) begin
          w_state_next  = SETTLE;
          w_phase_clear = 1'b1;
        end
      end
      SETTLE: begin
        if (r_phase == SETTLE_LAST) begin
          w_state_next  = COUNT;
          w_phase_clear = 1'b1;
        end
      end
      COUNT: begin
        if (r_phase == WINDOW_LAST) begin
          w_state_next  = DONE;
          w_phase_clear = 1'b1;
        end
      end
      DONE: begin
        w_state_next  = IDLE;
        w_phase_clear = 1'b1;
      end
      default: begin
        w_state_next  = IDLE;
        w_phase_clear = 1'b1;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_state      <= IDLE;
      r_phase      <= '0;
      ro_enable    <= 1'b0;
      busy         <= 1'b0;
      counts_valid <= 1'b0;
      count1       <= '0;
      count2       <= '0;
      for (int i = 0; i < 2; i++) begin
        r_acc[i] <= '0;
      end
    end else begin
      r_state      <= w_state_next;
      // Outputs are registered from the next state so they align with the state itself.
      ro_enable    <= (w_state_next == SETTLE) || (w_state_next == COUNT);
      busy         <= (w_state_next != IDLE);
      counts_valid <= (w_state_next == DONE);

      if (w_phase_clear) begin
        r_phase <= '0;
      end else if (r_state != IDLE) begin
        r_phase <= r_phase + 25'd1;
      end

      if ((r_state == IDLE) && start) begin
        for (int i = 0; i < 2; i++) begin
          r_acc[i] <= '0;
        end
      end else if (r_state == COUNT) begin
        for (int i = 0; i < 2; i++) begin
          r_acc[i] <= w_acc_next[i];
        end
      end

      // The last window cycle's pulse is folded in via the next-value path.
      if ((r_state == COUNT) && (w_state_next == DONE)) begin
        count1 <= w_acc_next[0];
        count2 <= w_acc_next[1];
      end
    end
  end

endmodule

// File: tb/tb_puf_window_counter.sv
// Cycle-stepped bench: a start-time based reference predicts outputs for every
// cycle; pulses are summed arithmetically over the expected counting window.
module tb_puf_window_counter;

  localparam int S = 2;
  localparam int W = 8;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        start;
  logic        ro_pulse_a;
  logic        ro_pulse_b;
  logic        ro_enable;
  logic        busy;
  logic [31:0] count1;
  logic [31:0] count2;
  logic        counts_valid;

  int checks = 0;
  int errors = 0;

  // Reference state: when the current measurement started and what it has seen.
  int          cyc_n;
  bit          m_active;
  int          m_first;
  longint      sum_a;
  longint      sum_b;
  logic [31:0] exp_c1;
  logic [31:0] exp_c2;
  bit          poke_a;

  puf_window_counter #(
    .WINDOW_CYCLES(W),
    .SETTLE_CYCLES(S)
  ) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .start       (start),
    .ro_pulse_a  (ro_pulse_a),
    .ro_pulse_b  (ro_pulse_b),
    .ro_enable   (ro_enable),
    .busy        (busy),
    .count1      (count1),
    .count2      (count2),
    .counts_valid(counts_valid)
  );

  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s cycle %0d got %h expected %h", tag, cyc_n, got, exp);
    end
  endtask

  function automatic logic [31:0] sat32(input longint v);
    return (v > 64'sh0000_0000_FFFF_FFFF) ? 32'hFFFF_FFFF : v[31:0];
  endfunction

  // One clock cycle: drive inputs, check outputs mid-cycle, advance the reference.
  task automatic cyc(input logic st, input logic a, input logic b, input logic rn);
    int rel;
    start      = st;
    ro_pulse_a = a;
    ro_pulse_b = b;
    rst_n      = rn;
    rel = m_active ? (cyc_n - m_first + 1) : 0;
    if (poke_a) begin
      dut.r_acc[0] = 32'hFFFF_FFFE;
      sum_a  = 64'h0000_0000_FFFF_FFFE;
      poke_a = 1'b0;
    end
    if (m_active && rel == S + W + 1) begin
      exp_c1 = sat32(sum_a);
      exp_c2 = sat32(sum_b);
    end
    @(negedge clk);
    check_eq("ro_enable", {31'd0, ro_enable}, {31'd0, m_active && rel >= 1 && rel <= S + W});
    check_eq("busy", {31'd0, busy}, {31'd0, m_active});
    check_eq("counts_valid", {31'd0, counts_valid}, {31'd0, m_active && rel == S + W + 1});
    check_eq("count1", count1, exp_c1);
    check_eq("count2", count2, exp_c2);
    if (m_active && rel == S + W + 1) begin
      $display("MEAS cycle %0d count1=%0d count2=%0d expected %0d/%0d", cyc_n, count1, count2, exp_c1, exp_c2);
    end
    if (!rn) begin
      m_active = 1'b0;
      exp_c1   = '0;
      exp_c2   = '0;
    end else if (m_active) begin
      if (rel >= S + 1 && rel <= S + W) begin
        sum_a += longint'(a);
        sum_b += longint'(b);
      end
      if (rel == S + W + 1) m_active = 1'b0;
    end else if (st) begin
      m_active = 1'b1;
      m_first  = cyc_n + 1;
      sum_a    = 0;
      sum_b    = 0;
    end
    @(posedge clk);
    #1;
    cyc_n++;
  endtask

  task automatic idle_cycles(input int n);
    for (int i = 0; i < n; i++) cyc(1'b0, 1'b0, 1'b0, 1'b1);
  endtask

  initial begin
    rst_n      = 1'b0;
    start      = 1'b0;
    ro_pulse_a = 1'b0;
    ro_pulse_b = 1'b0;
    m_active   = 1'b0;
    m_first    = 0;
    sum_a      = 0;
    sum_b      = 0;
    exp_c1     = '0;
    exp_c2     = '0;
    poke_a     = 1'b0;
    cyc_n      = 0;
    repeat (2) @(posedge clk);
    #1;
    cyc(1'b1, 1'b1, 1'b1, 1'b0);  // reset wins over start
    cyc(1'b0, 1'b0, 1'b0, 1'b0);
    idle_cycles(2);

    // Full-rate A, half-rate B inside the window.
    cyc(1'b1, 1'b0, 1'b0, 1'b1);
    for (int k = 1; k <= 12; k++) begin
      cyc(1'b0, (k >= 3 && k <= 10), (k >= 3 && k <= 10 && (k % 2) == 1), 1'b1);
    end
    check_eq("dir_count1_8", count1, 32'd8);
    check_eq("dir_count2_4", count2, 32'd4);

    // Pulses only outside the window (settle and done cycles).
    cyc(1'b1, 1'b0, 1'b0, 1'b1);
    for (int k = 1; k <= 12; k++) begin
      cyc(1'b0, (k <= 2 || k == 11), (k <= 2 || k == 11), 1'b1);
    end
    check_eq("dir_count1_0", count1, 32'd0);
    check_eq("dir_count2_0", count2, 32'd0);

    // Start re-pulsed mid-window, then held high for back-to-back runs.
    cyc(1'b1, 1'b0, 1'b0, 1'b1);
    for (int k = 1; k <= 12; k++) begin
      cyc((k == 5), 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), 1'b1);
    end
    for (int k = 0; k < 40; k++) begin
      cyc(1'b1, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), 1'b1);
    end
    idle_cycles(14);

    // Reset during the window after five counted pulses.
    cyc(1'b1, 1'b0, 1'b0, 1'b1);
    for (int k = 1; k <= 7; k++) cyc(1'b0, (k >= 3), (k >= 3), 1'b1);
    cyc(1'b0, 1'b1, 1'b1, 1'b0);
    idle_cycles(3);
    check_eq("dir_rst_count1", count1, 32'd0);
    cyc(1'b1, 1'b0, 1'b0, 1'b1);
    for (int k = 1; k <= 12; k++) cyc(1'b0, 1'($urandom_range(0, 1)), 1'b1, 1'b1);

    // Saturation: accumulator A preloaded near the top, three pulses follow.
    cyc(1'b1, 1'b0, 1'b0, 1'b1);
    for (int k = 1; k <= 12; k++) begin
      poke_a = (k == 3);
      cyc(1'b0, (k == 3 || k == 6 || k == 9), 1'b0, 1'b1);
    end
    check_eq("dir_sat_count1", count1, 32'hFFFF_FFFF);

    // Two measurements with different pulse densities, then random traffic.
    for (int m = 0; m < 12; m++) begin
      int rate;
      rate = (m == 0) ? 90 : ((m == 1) ? 20 : int'($urandom_range(0, 100)));
      cyc(1'b1, 1'b0, 1'b0, 1'b1);
      for (int k = 1; k <= 12 + int'($urandom_range(0, 3)); k++) begin
        cyc(1'($urandom_range(0, 9) == 0),
            1'($urandom_range(0, 99) < rate),
            1'($urandom_range(0, 99) < 100 - rate),
            (m < 2) ? 1'b1 : 1'($urandom_range(0, 29) != 0));
      end
    end
    idle_cycles(16);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/puf_window_counter.md
PUF_WINDOW_COUNTER -- requirements
Module: puf_window_counter

Interface
REQ-001 SHALL have parameter WINDOW_CYCLES, default 65536: length of the counting window in clk cycles, legal range 1..2^24.
REQ-002 SHALL have parameter SETTLE_CYCLES, default 16: oscillator warm-up cycles before counting starts, legal range 1..255.
REQ-003 SHALL have port clk, input, 1: the single system clock; all logic on its rising edge.
REQ-004 SHALL have port rst_n, input, 1: reset, synchronous, active-low.
REQ-005 SHALL have port start, input, 1: measurement request, sampled only in IDLE.
REQ-006 SHALL have port ro_pulse_a, input, 1: one-cycle pulse per RO A edge, already synchronized to clk by the front end.
REQ-007 SHALL have port ro_pulse_b, input, 1: one-cycle pulse per RO B edge, already synchronized to clk by the front end.
REQ-008 SHALL have port ro_enable, output, 1: enables both ring oscillators.
REQ-009 SHALL have port busy, output, 1: high while a measurement is in progress.
REQ-010 SHALL have port count1, output, 32: RO A pulse total for the last completed window; feeds the comparator count1 input.
REQ-011 SHALL have port count2, output, 32: RO B pulse total for the last completed window; feeds the comparator count2 input.
REQ-012 SHALL have port counts_valid, output, 1: one-cycle strobe marking new count1/count2.

Function
REQ-013 SHALL implement the FSM states IDLE, SETTLE, COUNT and DONE.
REQ-014 SHALL move IDLE->SETTLE on the first edge at which start=1; start in any other state SHALL be ignored and SHALL NOT be queued.
REQ-015 SHALL clear both internal accumulators and the phase counter on the IDLE->SETTLE transition.
REQ-016 SHALL stay in SETTLE for exactly SETTLE_CYCLES cycles, ignore ro_pulse_a/b there, then go to COUNT.
REQ-017 SHALL stay in COUNT for exactly WINDOW_CYCLES cycles and add 1 to accumulator A (B) in each COUNT cycle where ro_pulse_a (ro_pulse_b) is 1.
REQ-018 SHALL count a pulse in the last COUNT cycle, and SHALL NOT count pulses in the cycle before entering COUNT or the cycle after leaving it.
REQ-019 SHALL saturate each accumulator at 32'hFFFFFFFF with no wrap-around.
REQ-020 SHALL go COUNT->DONE, load count1/count2 from the accumulators on that edge, and assert counts_valid for exactly the one DONE cycle.
REQ-021 SHALL go DONE->IDLE unconditionally.
REQ-022 SHALL hold count1/count2 stable from DONE until the next DONE.
REQ-023 SHALL keep the previous count1/count2 values during SETTLE/COUNT of a new measurement.
REQ-024 SHALL drive ro_enable=1 exactly in SETTLE and COUNT.
REQ-025 SHALL drive busy=1 in SETTLE, COUNT and DONE, and busy=0 in IDLE.
REQ-026 SHALL have a latency, with start sampled at edge 0, of: counts_valid high in cycle SETTLE_CYCLES+WINDOW_CYCLES+1; busy low from cycle SETTLE_CYCLES+WINDOW_CYCLES+2.
REQ-027 SHALL accept a start held high continuously as a back-to-back request on each return to IDLE, giving one idle cycle between measurements.
REQ-028 SHALL drive all outputs from registers.

Reset
REQ-029 SHALL, when rst_n=0 at an edge, force state IDLE, ro_enable=0, busy=0, counts_valid=0, count1=0, count2=0, and clear accumulators and the phase counter.
REQ-030 SHALL abort a reset asserted mid-measurement (SETTLE/COUNT/DONE) with no counts_valid strobe, and return to IDLE on the first edge with rst_n=1.

Verification (SETTLE_CYCLES=2, WINDOW_CYCLES=8)
REQ-031 SHALL pass: start pulse at edge 0, ro_pulse_a high every COUNT cycle, ro_pulse_b every 2nd COUNT cycle -> counts_valid in cycle 11 only, count1=8, count2=4, ro_enable high in cycles 1-10.
REQ-032 SHALL pass: ro_pulse_a/b held high during SETTLE and in cycle 11 only -> count1=0, count2=0 at valid.
REQ-033 SHALL pass: start re-pulsed during COUNT -> ignored, one counts_valid, then IDLE; start held high -> next valid 12 cycles after the first.
REQ-034 SHALL pass: rst_n low for one cycle during COUNT after 5 counted pulses -> no counts_valid, all outputs 0, accepts start afterwards.
REQ-035 SHALL pass: accumulator A forced to 32'hFFFFFFFE by a white-box bench with 3 pulses in the window -> count1=32'hFFFFFFFF.
REQ-036 SHALL pass: two measurements with different pulse rates -> count1/count2 keep the first values until the second DONE, then update.
